cfs_rx_ctrl: RTL and testbench

RX controller of the Aligner. It sits between the memory-data (MD) RX slave interface and the RX FIFO, and checks each incoming transfer's offset/size for legality. Legal transfers are pushed into the RX FIFO with back-pressure. Illegal transfers are answered with an error and counted; the drop count and the `max_drop` flag feed the register block's `STATUS.CNT_DROP` field and `MAX_DROP` interrupt source.

---
 rtl/cfs_algn_pkg.sv | 46 ++++
 rtl/cfs_rx_ctrl_if.sv | 39 +++
 rtl/cfs_drop_counter.sv | 57 +++++
 rtl/cfs_rx_ctrl.sv | 139 +++++++++++++
 tb/tb_cfs_rx_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cfs_algn_pkg.sv
// ============================================================================
// Module      : cfs_algn_pkg
// Description : Shared Aligner definitions. Holds the width helper functions
//               derived from the MD data width, the RX controller FSM state
//               encoding, and the offset/size legality check. The register
//               block's CTRL write check also uses this legality function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfs_algn_pkg;

  // Width of the byte-offset field for a bus of 'bytes' bytes.
  function automatic int algn_offset_width(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

  // Width of the byte-count field. It needs one extra bit so that a full-width
  // transfer (size == bytes) can be represented.
  function automatic int algn_size_width(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  // RX controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    RESP = 2'd2
  } rx_state_t;

  // A transfer is legal when it has a non-zero size, is naturally aligned
  // relative to the end of the bus word, and fits inside the word.
  // Operands arrive zero-extended to 32 bits, which is wider than the
  // size field plus one, so neither sum can overflow.
  function automatic logic algn_is_legal(input int unsigned bytes,
                                         input int unsigned offset,
                                         input int unsigned size);
    if (size == 0) begin
      return 1'b0;
    end
    return (((bytes + offset) % size) == 0) && ((offset + size) <= bytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfs_rx_ctrl_if.sv
// ============================================================================
// Module      : cfs_rx_ctrl_if
// Description : Memory-data (MD) RX handshake bundle between an MD master and
//               the Aligner RX controller.
//               md_rx_valid/data/offset/size : master -> slave request
//               md_rx_ready/err              : slave -> master completion
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cfs_rx_ctrl_if #(
  parameter int ALGN_DATA_WIDTH = 32
);
  import cfs_algn_pkg::*;

  localparam int BYTES    = ALGN_DATA_WIDTH / 8;
  localparam int OFFSET_W = algn_offset_width(BYTES);
  localparam int SIZE_W   = algn_size_width(BYTES);

  logic                       md_rx_valid;
  logic [ALGN_DATA_WIDTH-1:0] md_rx_data;
  logic [OFFSET_W-1:0]        md_rx_offset;
  logic [SIZE_W-1:0]          md_rx_size;
  logic                       md_rx_ready;
  logic                       md_rx_err;

  modport master (
    output md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
    input  md_rx_ready, md_rx_err
  );

  modport slave (
    input  md_rx_valid, md_rx_data, md_rx_offset, md_rx_size,
    output md_rx_ready, md_rx_err
  );

endinterface

`default_nettype wire

// File: rtl/cfs_drop_counter.sv
// ============================================================================
// Module      : cfs_drop_counter
// Description : Saturating dropped-transfer counter with clear priority and a
//               registered all-ones flag.
//               pclk/presetn : clock, asynchronous active-low reset
//               clr          : clear pulse, wins over inc
//               inc          : count one dropped transfer
//               cnt          : current count
//               max_flag     : high while cnt is all-ones
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfs_drop_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  wire logic                 pclk,
  input  wire logic                 presetn,
  input  wire logic                 clr,
  input  wire logic                 inc,
  output logic      [CNT_WIDTH-1:0] cnt,
  output logic                      max_flag
);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_max;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && (r_cnt != C_CNT_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // The flag is computed from the next count so it switches on the same
  // edge as the counter rather than one cycle behind it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_cnt <= '0;
      r_max <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_max <= (w_cnt_nxt == C_CNT_MAX);
    end
  end

  assign cnt      = r_cnt;
  assign max_flag = r_max;

endmodule

`default_nettype wire

// File: rtl/cfs_rx_ctrl.sv
// ============================================================================
// Module      : cfs_rx_ctrl
// Description : Aligner RX controller. Checks each MD RX transfer for offset/
//               size legality, pushes legal transfers into the RX FIFO with
//               back-pressure, and answers illegal ones with an error while
//               counting them.
//               pclk/presetn    : clock, asynchronous active-low reset
//               md_rx           : MD RX slave handshake (interface)
//               push_valid/data : RX FIFO push, data = {size, offset, data}
//               push_ready      : RX FIFO not full
//               ctrl_clr        : clears the drop counter
//               status_cnt_drop : dropped-transfer count
//               max_drop        : drop count is all-ones
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfs_rx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter  int ALGN_DATA_WIDTH       = 32,
  parameter  int STATUS_CNT_DROP_WIDTH = 8,
  localparam int BYTES                 = ALGN_DATA_WIDTH / 8,
  localparam int ALGN_OFFSET_WIDTH     = algn_offset_width(BYTES),
  localparam int ALGN_SIZE_WIDTH       = algn_size_width(BYTES),
  localparam int PUSH_WIDTH            = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH
) (
  input  wire logic                             pclk,
  input  wire logic                             presetn,
  cfs_rx_ctrl_if.slave                          md_rx,
  output logic                                  push_valid,
  output logic      [PUSH_WIDTH-1:0]            push_data,
  input  wire logic                             push_ready,
  input  wire logic                             ctrl_clr,
  output logic      [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  output logic                                  max_drop
);

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic                  r_push_valid;
  logic                  w_push_valid_nxt;
  logic [PUSH_WIDTH-1:0] r_push_data;
  logic [PUSH_WIDTH-1:0] w_push_data_nxt;
  logic                  w_legal;
  logic                  w_drop;

  assign w_legal = algn_is_legal(BYTES,
                                 32'(md_rx.md_rx_offset),
                                 32'(md_rx.md_rx_size));

  // Next-state and next-output logic. md_rx_ready/err default low so they
  // form a one-cycle pulse; the push payload defaults to holding its value.
  always_comb begin
    w_state_nxt      = r_state;
    w_ready_nxt      = 1'b0;
    w_err_nxt        = 1'b0;
    w_push_valid_nxt = r_push_valid;
    w_push_data_nxt  = r_push_data;
    w_drop           = 1'b0;

    case (r_state)
      IDLE: begin
        if (md_rx.md_rx_valid) begin
          if (w_legal) begin
            w_push_valid_nxt = 1'b1;
            w_push_data_nxt  = {md_rx.md_rx_size, md_rx.md_rx_offset, md_rx.md_rx_data};
            w_state_nxt      = PUSH;
          end else begin
            w_ready_nxt = 1'b1;
            w_err_nxt   = 1'b1;
            w_drop      = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end

      // The payload was captured on entry, so a master that drops valid
      // while we wait here does not affect the pending push.
      PUSH: begin
        if (push_ready) begin
          w_push_valid_nxt = 1'b0;
          w_ready_nxt      = 1'b1;
          w_state_nxt      = RESP;
        end
      end

      // The master still holds its request while it sees ready, so the
      // input is deliberately ignored here to avoid accepting it twice.
      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_push_valid_nxt = 1'b0;
        w_state_nxt      = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_err        <= w_err_nxt;
      r_push_valid <= w_push_valid_nxt;
      r_push_data  <= w_push_data_nxt;
    end
  end

  assign md_rx.md_rx_ready = r_ready;
  assign md_rx.md_rx_err   = r_err;
  assign push_valid        = r_push_valid;
  assign push_data         = r_push_data;

  cfs_drop_counter #(
    .CNT_WIDTH (STATUS_CNT_DROP_WIDTH)
  ) u_drop_counter (
    .pclk     (pclk),
    .presetn  (presetn),
    .clr      (ctrl_clr),
    .inc      (w_drop),
    .cnt      (status_cnt_drop),
    .max_flag (max_drop)
  );

endmodule

`default_nettype wire

// File: tb/tb_cfs_rx_ctrl.sv
// ============================================================================
// Module      : tb_cfs_rx_ctrl
// Description : Directed self-checking bench for cfs_rx_ctrl (32-bit data,
//               2-bit drop counter).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfs_rx_ctrl;

  localparam int DW   = 32;
  localparam int CW   = 2;
  localparam int PW   = 32 + 2 + 3;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          push_valid;
  logic [PW-1:0] push_data;
  logic          push_ready = 1'b0;
  logic          ctrl_clr = 1'b0;
  logic [CW-1:0] status_cnt_drop;
  logic          max_drop;

  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;

  cfs_rx_ctrl_if #(.ALGN_DATA_WIDTH(DW)) md_rx ();

  cfs_rx_ctrl #(
    .ALGN_DATA_WIDTH       (DW),
    .STATUS_CNT_DROP_WIDTH (CW)
  ) dut (
    .pclk            (pclk),
    .presetn         (presetn),
    .md_rx           (md_rx.slave),
    .push_valid      (push_valid),
    .push_data       (push_data),
    .push_ready      (push_ready),
    .ctrl_clr        (ctrl_clr),
    .status_cnt_drop (status_cnt_drop),
    .max_drop        (max_drop)
  );

  always #5 pclk = ~pclk;

  // Counts accepted pushes; inputs change 1 time unit after the edge so
  // they are stable here.
  always @(posedge pclk) begin
    if (push_valid && push_ready) n_push <= n_push + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] data, input logic [1:0] off, input logic [2:0] size);
    md_rx.md_rx_valid  = 1'b1;
    md_rx.md_rx_data   = data;
    md_rx.md_rx_offset = off;
    md_rx.md_rx_size   = size;
  endtask

  task automatic release_req();
    md_rx.md_rx_valid = 1'b0;
  endtask

  // Illegal transfer: error pulse one cycle after sampling, no push.
  task automatic send_illegal(input logic [1:0] off, input logic [2:0] size,
                              input logic clr, input logic [CW-1:0] exp_cnt,
                              input logic exp_max);
    drive(32'hDEADBEEF, off, size);
    ctrl_clr = clr;
    tick();
    ctrl_clr = 1'b0;
    check("ill_ready", 64'(md_rx.md_rx_ready), 64'd1);
    check("ill_err",   64'(md_rx.md_rx_err),   64'd1);
    check("ill_push",  64'(push_valid),        64'd0);
    check("ill_cnt",   64'(status_cnt_drop),   64'(exp_cnt));
    check("ill_max",   64'(max_drop),          64'(exp_max));
    release_req();
    tick();
    check("ill_ready_off", 64'(md_rx.md_rx_ready), 64'd0);
    check("ill_err_off",   64'(md_rx.md_rx_err),   64'd0);
  endtask

  task automatic pulse_clr();
    ctrl_clr = 1'b1;
    tick();
    ctrl_clr = 1'b0;
    check("clr_cnt", 64'(status_cnt_drop), 64'd0);
    check("clr_max", 64'(max_drop),        64'd0);
  endtask

  // Legal transfer with the FIFO ready: push in k+1, completion in k+2.
  task automatic send_legal(input logic [31:0] data, input logic [1:0] off,
                            input logic [2:0] size, input logic [CW-1:0] exp_cnt);
    int p0;
    p0 = n_push;
    push_ready = 1'b1;
    drive(data, off, size);
    tick();
    check("leg_pv",    64'(push_valid),        64'd1);
    check("leg_pd",    64'(push_data),         64'({size, off, data}));
    check("leg_rdy0",  64'(md_rx.md_rx_ready), 64'd0);
    tick();
    check("leg_rdy",   64'(md_rx.md_rx_ready), 64'd1);
    check("leg_err",   64'(md_rx.md_rx_err),   64'd0);
    check("leg_pv0",   64'(push_valid),        64'd0);
    check("leg_cnt",   64'(status_cnt_drop),   64'(exp_cnt));
    release_req();
    tick();
    check("leg_rdy_off", 64'(md_rx.md_rx_ready), 64'd0);
    check("leg_npush",   64'(n_push - p0),       64'd1);
  endtask

  initial begin
    md_rx.md_rx_valid  = 1'b0;
    md_rx.md_rx_data   = '0;
    md_rx.md_rx_offset = '0;
    md_rx.md_rx_size   = '0;

    // Reset state
    #12;
    check("rst_ready", 64'(md_rx.md_rx_ready), 64'd0);
    check("rst_err",   64'(md_rx.md_rx_err),   64'd0);
    check("rst_pv",    64'(push_valid),        64'd0);
    check("rst_pd",    64'(push_data),         64'd0);
    check("rst_cnt",   64'(status_cnt_drop),   64'd0);
    check("rst_max",   64'(max_drop),          64'd0);
    presetn = 1'b1;
    tick();

    // Legal: offset 2, size 2
    send_legal(32'hAABBCCDD, 2'd2, 3'd2, 2'd0);
    // Legal: full word
    send_legal(32'h01020304, 2'd0, 3'd4, 2'd0);

    // Illegal sweep
    send_illegal(2'd1, 3'd2, 1'b0, 2'd1, 1'b0);
    send_illegal(2'd2, 3'd3, 1'b0, 2'd2, 1'b0);
    send_illegal(2'd0, 3'd0, 1'b0, 2'd3, 1'b1);
    pulse_clr();

    // Saturation: 1, 2, 3, 3, 3
    send_illegal(2'd1, 3'd2, 1'b0, 2'd1, 1'b0);
    send_illegal(2'd1, 3'd2, 1'b0, 2'd2, 1'b0);
    send_illegal(2'd1, 3'd2, 1'b0, 2'd3, 1'b1);
    send_illegal(2'd1, 3'd2, 1'b0, 2'd3, 1'b1);
    send_illegal(2'd1, 3'd2, 1'b0, 2'd3, 1'b1);
    pulse_clr();

    // Clear collides with a drop at count 2
    send_illegal(2'd3, 3'd2, 1'b0, 2'd1, 1'b0);
    send_illegal(2'd3, 3'd2, 1'b0, 2'd2, 1'b0);
    send_illegal(2'd3, 3'd2, 1'b1, 2'd0, 1'b0);

    // Back-pressure: FIFO full for 5 cycles
    begin
      int p0;
      p0 = n_push;
      push_ready = 1'b0;
      drive(32'h12345678, 2'd0, 3'd4);
      tick();
      release_req();  // protocol violation: the captured transfer must still complete
      for (int i = 0; i < 5; i++) begin
        check("bp_pv",  64'(push_valid),        64'd1);
        check("bp_pd",  64'(push_data),         64'({3'd4, 2'd0, 32'h12345678}));
        check("bp_rdy", 64'(md_rx.md_rx_ready), 64'd0);
        tick();
      end
      push_ready = 1'b1;
      check("bp_pv_last", 64'(push_valid), 64'd1);
      tick();
      check("bp_rdy",   64'(md_rx.md_rx_ready), 64'd1);
      check("bp_err",   64'(md_rx.md_rx_err),   64'd0);
      check("bp_pv0",   64'(push_valid),        64'd0);
      tick();
      check("bp_npush", 64'(n_push - p0),       64'd1);
      check("bp_rdy_off", 64'(md_rx.md_rx_ready), 64'd0);
    end

    // Reset mid-PUSH (with a non-zero count to prove it clears)
    send_illegal(2'd1, 3'd2, 1'b0, 2'd1, 1'b0);
    push_ready = 1'b0;
    drive(32'hCAFEF00D, 2'd0, 3'd4);
    tick();
    check("rp_pv", 64'(push_valid), 64'd1);
    #2;
    presetn = 1'b0;
    #1;
    check("rp_pv0",  64'(push_valid),        64'd0);
    check("rp_pd0",  64'(push_data),         64'd0);
    check("rp_rdy0", 64'(md_rx.md_rx_ready), 64'd0);
    check("rp_err0", 64'(md_rx.md_rx_err),   64'd0);
    check("rp_cnt0", 64'(status_cnt_drop),   64'd0);
    release_req();
    tick();
    presetn = 1'b1;
    tick();
    check("rp_idle_pv", 64'(push_valid), 64'd0);
    send_legal(32'h0BADC0DE, 2'd1, 3'd1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
